wb_write_buffer: RTL and testbench
==================================

WB_WRITE_BUFFER -- requirements
Module: wb_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered write-back entries (power of 2, 2..8).
REQ-002 Parameter NREG, default 16, number of architectural registers (register index width 4).
REQ-003 Parameter WIDTH, default 16, register data width.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  write-back request present.
REQ-007 in_ready  output  1  buffer can accept a request this cycle.
REQ-008 in_reg  input  4  destination register index.
REQ-009 in_data  input  WIDTH  destination data.
REQ-010 hold  input  1  register file not writable this cycle; suppresses drain.
REQ-011 WriteReg  output  NREG  one-hot per-register write enable into the register file.
REQ-012 DstData  output  WIDTH  data driven to every register's data input.
REQ-013 SrcReg1, SrcReg2  input  4 each  read-port register indices.
REQ-014 hit1, hit2  output  1 each  read-port index matches a pending entry.
REQ-015 fwd_data1, fwd_data2  output  WIDTH each  pending data for the matching read port.
REQ-016 count  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-017 Storage is a circular FIFO of DEPTH entries {reg, data} with head and tail pointers that wrap modulo DEPTH.
REQ-018 in_ready is 1 iff count < DEPTH; a full buffer refuses input even when draining that cycle.
REQ-019 Push occurs when in_valid && in_ready && in_reg != 0; the entry is written at tail and tail advances.
REQ-020 A request with in_reg == 0 while in_ready is 1 is consumed and discarded (R0 is hardwired zero); no entry is written.
REQ-021 Drain occurs when count > 0 && !hold; the head entry is presented and head advances at the clock edge.
REQ-022 WriteReg is combinational: one-hot of the head entry's reg when a drain occurs, else all zeros; DstData is the head data during drain, else 0.
REQ-023 Write latency: an accepted push into an empty buffer appears on WriteReg in the next cycle (minimum one cycle).
REQ-024 Simultaneous push and drain: count unchanged; both pointers advance.
REQ-025 count increments on push-only, decrements on drain-only, and never exceeds DEPTH or goes below 0.
REQ-026 Entries drain strictly in arrival order; two entries to the same register are both written, oldest first.
REQ-027 hit/fwd are combinational over occupied entries only (not the in_* request of the current cycle); on multiple matches the youngest entry wins.
REQ-028 SrcRegN == 0 always yields hitN = 0 and fwd_dataN = 0; with no match, fwd_dataN = 0.
REQ-029 The head entry remains visible to bypass during its drain cycle.

Reset
REQ-030 On rst low, asynchronously: head = tail = 0, count = 0, all entry fields = 0; WriteReg = 0, DstData = 0, hit1 = hit2 = 0, and in_ready = 1.
REQ-031 Reset asserted mid-operation discards all pending entries; none are written to the register file.
REQ-032 The first push is accepted on the first rising edge after rst returns high.

Configuration
REQ-033 Macro WB_BYPASS_EN: when defined, REQ-027..029 forwarding logic is compiled in.
REQ-034 When WB_BYPASS_EN is not defined, hit1, hit2, fwd_data1 and fwd_data2 are constant 0 and no compare logic exists; all other behaviour is unchanged.

Verification
REQ-035 After reset, push R3=0x1234 -> next cycle WriteReg=0x0008, DstData=0x1234; count goes 1->0.
REQ-036 With hold=1, push R1..R4 (0x11,0x22,0x33,0x44) -> count=4, in_ready=0; a fifth push is not accepted; release hold -> WriteReg 0x0002,0x0004,0x0008,0x0010 on consecutive cycles.
REQ-037 With hold=1, push R5=0xAAAA then R5=0xBBBB; SrcReg1=5 -> hit1=1, fwd_data1=0xBBBB; SrcReg2=6 -> hit2=0; SrcReg1=0 -> hit1=0.
REQ-038 Push R0=0xFFFF -> accepted, count stays 0, WriteReg stays 0.
REQ-039 Fill 3 entries under hold, then simultaneous push and drain for 6 cycles -> count stays 3, pointers wrap, order preserved.
REQ-040 Assert rst low with 2 entries pending -> WriteReg=0, count=0 immediately; after release, no stale writes appear.

Source files
------------

// File: rtl/wb_write_buffer.sv
// ============================================================================
// wb_write_buffer : circular write-back buffer in front of a register file,
//                   with optional read-port forwarding (macro WB_BYPASS_EN).
// Revision 1.0
// ============================================================================
`default_nettype none

module wb_write_buffer #(
   parameter int DEPTH = 4,
   parameter int NREG  = 16,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_reg,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     hold,
   output logic [NREG-1:0]          WriteReg,
   output logic [WIDTH-1:0]         DstData,
   input  logic [3:0]               SrcReg1,
   input  logic [3:0]               SrcReg2,
   output logic                     hit1,
   output logic                     hit2,
   output logic [WIDTH-1:0]         fwd_data1,
   output logic [WIDTH-1:0]         fwd_data2,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int             PW   = $clog2(DEPTH);
   localparam int             CW   = PW + 1;
   localparam logic [CW-1:0]  FULL = CW'(DEPTH);

   logic [3:0]       reg_q  [DEPTH];
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic             push;
   logic             drain;

   assign in_ready = (count < FULL);
   // R0 requests are consumed (in_ready high) but never stored.
   assign push     = in_valid && in_ready && (in_reg != 4'd0);
   assign drain    = (count != '0) && !hold;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            reg_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         if (push) begin
            reg_q[tail]  <= in_reg;
            data_q[tail] <= in_data;
            tail         <= tail + 1'b1;
         end
         if (drain) begin
            head <= head + 1'b1;
         end
         case ({push, drain})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      WriteReg = '0;
      DstData  = '0;
      if (drain) begin
         WriteReg = NREG'(1) << reg_q[head];
         DstData  = data_q[head];
      end
   end

`ifdef WB_BYPASS_EN
   // Scan oldest to youngest so the youngest matching entry wins.
   always_comb begin
      hit1      = 1'b0;
      hit2      = 1'b0;
      fwd_data1 = '0;
      fwd_data2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < count) begin
            if (SrcReg1 != 4'd0 && reg_q[head + PW'(i)] == SrcReg1) begin
               hit1      = 1'b1;
               fwd_data1 = data_q[head + PW'(i)];
            end
            if (SrcReg2 != 4'd0 && reg_q[head + PW'(i)] == SrcReg2) begin
               hit2      = 1'b1;
               fwd_data2 = data_q[head + PW'(i)];
            end
         end
      end
   end
`else
   logic unused_src;
   assign unused_src = ^{SrcReg1, SrcReg2};
   assign hit1       = 1'b0;
   assign hit2       = 1'b0;
   assign fwd_data1  = '0;
   assign fwd_data2  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_write_buffer.sv
// Scoreboard bench for wb_write_buffer: expected register-file writes are
// queued at issue time and popped by a negedge monitor.
`default_nettype none

module tb_wb_write_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_reg = '0;
   logic [15:0] in_data = '0;
   logic        hold = 1'b0;
   logic [15:0] WriteReg;
   logic [15:0] DstData;
   logic [3:0]  SrcReg1 = '0;
   logic [3:0]  SrcReg2 = '0;
   logic        hit1, hit2;
   logic [15:0] fwd_data1, fwd_data2;
   logic [2:0]  count;

   typedef struct packed {
      logic [3:0]  r;
      logic [15:0] d;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   wb_write_buffer #(.DEPTH(4), .NREG(16), .WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
      .hold(hold), .WriteReg(WriteReg), .DstData(DstData),
      .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
      .hit1(hit1), .hit2(hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
      .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   // Monitor: every register-file write must match the oldest expected one.
   wr_t         mon_e;
   logic [15:0] mon_oh;
   always @(negedge clk) begin
      if (rst) begin
         checks++;
         if (WriteReg != 16'h0) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write WriteReg=%h DstData=%h required=none", WriteReg, DstData);
            end else begin
               mon_e  = exp_q.pop_front();
               mon_oh = 16'h0001 << mon_e.r;
               if (WriteReg !== mon_oh || DstData !== mon_e.d) begin
                  errors++;
                  $display("FAIL write_order WriteReg=%h DstData=%h required WriteReg=%h DstData=%h",
                           WriteReg, DstData, mon_oh, mon_e.d);
               end
            end
         end else if (DstData !== 16'h0) begin
            errors++;
            $display("FAIL idle_data DstData=%h required=0000", DstData);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic push(input logic [3:0] r, input logic [15:0] d, input bit expect_write);
      in_valid = 1'b1;
      in_reg   = r;
      in_data  = d;
      if (expect_write) exp_q.push_back('{r: r, d: d});
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      step();
      step();
      chk("rst_count", 32'(count), 0);
      chk("rst_ready", 32'(in_ready), 1);
      chk("rst_writereg", 32'(WriteReg), 0);
      chk("rst_dstdata", 32'(DstData), 0);
      chk("rst_hit1", 32'(hit1), 0);
      chk("rst_hit2", 32'(hit2), 0);
      rst = 1'b1;

      // Single push, one-cycle write latency
      push(4'd3, 16'h1234, 1'b1);
      chk("single_count1", 32'(count), 1);
      step();
      chk("single_count0", 32'(count), 0);

      // Fill under hold, refuse fifth, drain in order
      hold = 1'b1;
      push(4'd1, 16'h0011, 1'b1);
      push(4'd2, 16'h0022, 1'b1);
      push(4'd3, 16'h0033, 1'b1);
      push(4'd4, 16'h0044, 1'b1);
      chk("full_count", 32'(count), 4);
      chk("full_ready", 32'(in_ready), 0);
      push(4'd5, 16'h0055, 1'b0);
      chk("full_refuse_count", 32'(count), 4);
      hold = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("drain_count", 32'(count), 32'(4 - k));
         step();
      end
      chk("drain_empty", 32'(count), 0);

      // Forwarding: youngest match wins, R0 never hits
      hold = 1'b1;
      push(4'd5, 16'hAAAA, 1'b1);
      push(4'd5, 16'hBBBB, 1'b1);
      SrcReg1 = 4'd5;
      SrcReg2 = 4'd6;
      #1;
      chk("fwd_hit1", 32'(hit1), 32'(BYP));
      chk("fwd_data1", 32'(fwd_data1), BYP ? 32'hBBBB : 32'h0);
      chk("fwd_hit2_miss", 32'(hit2), 0);
      chk("fwd_data2_miss", 32'(fwd_data2), 0);
      SrcReg1 = 4'd0;
      #1;
      chk("fwd_r0_hit", 32'(hit1), 0);
      chk("fwd_r0_data", 32'(fwd_data1), 0);
      SrcReg1 = 4'd5;
      hold = 1'b0;
      #1;
      chk("fwd_during_drain", 32'(fwd_data1), BYP ? 32'hBBBB : 32'h0);
      step();
      chk("fwd_last_hit", 32'(hit1), 32'(BYP));
      chk("fwd_last_data", 32'(fwd_data1), BYP ? 32'hBBBB : 32'h0);
      step();
      chk("fwd_empty_hit", 32'(hit1), 0);
      SrcReg1 = 4'd0;
      SrcReg2 = 4'd0;

      // R0 write is consumed and dropped
      chk("r0_ready", 32'(in_ready), 1);
      push(4'd0, 16'hFFFF, 1'b0);
      chk("r0_count", 32'(count), 0);
      step();

      // Simultaneous push and drain with pointer wrap
      hold = 1'b1;
      push(4'd6, 16'h0601, 1'b1);
      push(4'd7, 16'h0702, 1'b1);
      push(4'd8, 16'h0803, 1'b1);
      hold = 1'b0;
      for (int k = 0; k < 6; k++) begin
         push(4'(9 + k), 16'h0900 + 16'(k), 1'b1);
         chk("stream_count", 32'(count), 3);
      end
      step();
      step();
      step();
      chk("stream_empty", 32'(count), 0);

      // Reset mid-operation discards pending entries
      hold = 1'b1;
      push(4'd2, 16'h2222, 1'b0);
      push(4'd3, 16'h3333, 1'b0);
      chk("prerst_count", 32'(count), 2);
      rst = 1'b0;
      #1;
      chk("midrst_count", 32'(count), 0);
      chk("midrst_writereg", 32'(WriteReg), 0);
      chk("midrst_ready", 32'(in_ready), 1);
      hold = 1'b0;
      step();
      step();
      rst = 1'b1;
      SrcReg1 = 4'd2;
      #1;
      chk("postrst_hit1", 32'(hit1), 0);
      chk("postrst_count", 32'(count), 0);
      SrcReg1 = 4'd0;
      step();
      step();
      step();

      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
